// File: rtl/ann_pkg.sv
// Shared definitions for the neuron datapath: data widths, the largest
// sign-magnitude magnitude and the accumulator FSM state encoding.
package ann_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned FRAC_W = 12;

    // Largest positive sign-magnitude value (+7.99976 in Q3.12)
    localparam logic [DATA_W-1:0] SM_MAX = 16'h7FFF;

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_BIAS = 2'd1,
        ST_SAT  = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

endpackage

// File: rtl/sm_pretvorba.sv
// Sign-magnitude to two's-complement conversion (combinational).
// Ports:
//   sm_i : sign-magnitude word (bit 15 sign, bits 14:0 magnitude)
//   tc_o : same value in two's complement; negative zero maps to 0
module sm_pretvorba
    import ann_pkg::*;
(
    input  logic        [DATA_W-1:0] sm_i,
    output logic signed [DATA_W-1:0] tc_o
);

    logic signed [DATA_W-1:0] mag_c;

    // Magnitude is at most 0x7FFF, so negation never overflows and -0 == 0
    assign mag_c = {1'b0, sm_i[DATA_W-2:0]};
    assign tc_o  = sm_i[DATA_W-1] ? -mag_c : mag_c;

endmodule

// File: rtl/akumulator_neurona.sv
// Neuron accumulator: sums N_INPUTS sign-magnitude Q3.12 products, adds a
// bias captured with the first product, saturates to +/-32767 and returns
// a sign-magnitude Q3.12 pre-activation value over a valid/ready handshake.
// Optional build macro AKUMULATOR_RELU_EN: negative results become 0x0000.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : product input handshake (ready only in ACC)
//   product, bias       : sign-magnitude Q3.12 inputs
//   out_valid/out_ready : result handshake, sum held stable while valid
//   sum                 : sign-magnitude Q3.12 result (never 0x8000)
module akumulator_neurona
    import ann_pkg::*;
#(
    parameter int unsigned N_INPUTS = 60,
    parameter int unsigned ACC_W    = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] product,
    input  logic [DATA_W-1:0] bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum
);

    localparam int unsigned EXT_W = ACC_W - DATA_W;
    localparam logic [7:0]  LAST_CNT = 8'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(SM_MAX);
    localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI;

    state_e state_q, state_d;

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [7:0]               cnt_q, cnt_d;
    logic signed [DATA_W-1:0] bias_q, bias_d;
    logic [DATA_W-1:0]        sum_q, sum_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;

    logic signed [DATA_W-1:0] prod_tc_c, bias_tc_c, clamp_c;
    logic                     accept_c, last_c, clamp_neg_c;
    logic [DATA_W-2:0]        clamp_mag_c;

    sm_pretvorba u_prod_conv (
        .sm_i (product),
        .tc_o (prod_tc_c)
    );

    sm_pretvorba u_bias_conv (
        .sm_i (bias),
        .tc_o (bias_tc_c)
    );

    assign accept_c = in_valid && in_ready_q;
    assign last_c   = (cnt_q == LAST_CNT);

    // Clamp the full-width accumulator into the symmetric 16-bit range
    always_comb begin
        clamp_c = acc_q[DATA_W-1:0];
        if (acc_q > SAT_HI) begin
            clamp_c = $signed(SM_MAX);
        end else if (acc_q < SAT_LO) begin
            clamp_c = -$signed(SM_MAX);
        end
    end

    assign clamp_neg_c = clamp_c[DATA_W-1];
    assign clamp_mag_c = clamp_neg_c ? (DATA_W-1)'(-clamp_c) : (DATA_W-1)'(clamp_c);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:  if (accept_c && last_c) state_d = ST_BIAS;
            ST_BIAS: state_d = ST_SAT;
            ST_SAT:  state_d = ST_OUT;
            ST_OUT:  if (out_ready) state_d = ST_ACC;
            default: state_d = ST_ACC;
        endcase
    end

    // Handshake outputs follow the upcoming state so they are registered
    always_comb begin
        in_ready_d  = (state_d == ST_ACC);
        out_valid_d = (state_d == ST_OUT);
    end

    // Datapath next-state: accumulate, add bias, saturate, release
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        bias_d = bias_q;
        sum_d  = sum_q;
        case (state_q)
            ST_ACC: begin
                if (accept_c) begin
                    acc_d = acc_q + {{EXT_W{prod_tc_c[DATA_W-1]}}, prod_tc_c};
                    cnt_d = last_c ? 8'd0 : cnt_q + 8'd1;
                    if (cnt_q == 8'd0) begin
                        bias_d = bias_tc_c;
                    end
                end
            end
            ST_BIAS: begin
                acc_d = acc_q + {{EXT_W{bias_q[DATA_W-1]}}, bias_q};
            end
            ST_SAT: begin
                // Negative results always have non-zero magnitude, so no -0
`ifdef AKUMULATOR_RELU_EN
                sum_d = clamp_neg_c ? '0 : {1'b0, clamp_mag_c};
`else
                sum_d = {clamp_neg_c, clamp_mag_c};
`endif
            end
            ST_OUT: begin
                if (out_ready) begin
                    acc_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= 8'd0;
            bias_q      <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            bias_q      <= bias_d;
            sum_q       <= sum_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;

endmodule

// File: tb/tb_akumulator_neurona.sv
// Self-checking bench for akumulator_neurona (N_INPUTS=4 and N_INPUTS=60).
module tb_akumulator_neurona;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] product, bias, sum;
    logic        in_valid60, in_ready60, out_valid60, out_ready60;
    logic [15:0] product60, bias60, sum60;

    int n_checks = 0;
    int n_errors = 0;
    bit ov_allowed = 1'b0;
    logic [15:0] pv [64];

    always #5 clk = ~clk;

    akumulator_neurona #(.N_INPUTS(4), .ACC_W(24)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .product(product), .bias(bias), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum)
    );

    akumulator_neurona #(.N_INPUTS(60), .ACC_W(24)) dut60 (
        .clk(clk), .rst(rst), .in_valid(in_valid60), .in_ready(in_ready60),
        .product(product60), .bias(bias60), .out_valid(out_valid60),
        .out_ready(out_ready60), .sum(sum60)
    );

    // Reference model: plain integer arithmetic on sign-magnitude values
    function automatic int sm_val(input logic [15:0] x);
        int m;
        m = int'(x[14:0]);
        return x[15] ? -m : m;
    endfunction

    function automatic logic [15:0] ref_sum(input int total);
        int c;
        c = (total > 32767) ? 32767 : (total < -32767) ? -32767 : total;
        if (c < 0) begin
`ifdef AKUMULATOR_RELU_EN
            return 16'h0000;
`else
            return {1'b1, 15'(-c)};
`endif
        end
        return {1'b0, 15'(c)};
    endfunction

    // out_valid must never appear while a test is not expecting a result
    always @(negedge clk) begin
        if (!rst && !ov_allowed) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL spurious_out_valid: got %b expected 0 at %0t", out_valid, $time);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives n products from pv[]; bias is only meaningful on the first accept
    task automatic feed(input int n, input logic [15:0] b, input bit gaps,
                        output logic [15:0] exp_sum);
        int total;
        int g;
        ov_allowed = 1'b0;
        total = sm_val(b);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    in_valid = 1'b0;
                    product  = 16'($urandom);
                    bias     = 16'($urandom);
                    step(1);
                end
            end
            in_valid = 1'b1;
            product  = pv[i];
            bias     = (i == 0) ? b : 16'($urandom);
            total += sm_val(pv[i]);
            step(1);
        end
        in_valid = 1'b0;
        bias     = 16'($urandom);
        exp_sum  = ref_sum(total);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; product = '0; bias = '0;
        in_valid60 = 1'b0; out_ready60 = 1'b0; product60 = '0; bias60 = '0;
        step(3);
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b sum=%h expected 1 0 0000", in_ready, out_valid, sum);
        end
    endtask

    task automatic test_basic();
        logic [15:0] e;
        for (int i = 0; i < 4; i++) pv[i] = 16'h1000;
        feed(4, 16'h0000, 1'b0, e);
        ov_allowed = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_lat1: got vld=%b rdy=%b expected 0 0", out_valid, in_ready);
        end
        step(1);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_lat2: got vld=%b expected 0", out_valid);
        end
        step(1);
        n_checks++;
        if (out_valid !== 1'b1 || sum !== 16'h4000 || e !== 16'h4000) begin
            n_errors++;
            $display("FAIL basic_sum: got vld=%b sum=%h expected 1 4000", out_valid, sum);
        end
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        ov_allowed = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_release: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    // Directed sign, negative-zero and saturation-edge cases
    task automatic test_directed();
        logic [15:0] e, b, want;
        for (int t = 0; t < 5; t++) begin
            case (t)
                0: begin for (int i = 0; i < 4; i++) pv[i] = 16'h9000; b = 16'h1000; end
                1: begin for (int i = 0; i < 4; i++) pv[i] = 16'h8000; b = 16'h8000; end
                2: begin pv[0] = 16'h7FFF; pv[1] = 16'h0001; pv[2] = 16'h0000; pv[3] = 16'h0000; b = 16'h8001; end
                3: begin pv[0] = 16'hFFFF; pv[1] = 16'h8001; pv[2] = 16'h0000; pv[3] = 16'h8000; b = 16'h0001; end
                default: begin for (int i = 0; i < 4; i++) pv[i] = 16'h7FFF; b = 16'h7FFF; end
            endcase
            feed(4, b, 1'b1, e);
            case (t)
`ifdef AKUMULATOR_RELU_EN
                0: want = 16'h0000;
                3: want = 16'h0000;
`else
                0: want = 16'hB000;
                3: want = 16'hFFFF;
`endif
                1: want = 16'h0000;
                default: want = 16'h7FFF;
            endcase
            ov_allowed = 1'b1;
            step(2);
            n_checks++;
            if (out_valid !== 1'b1 || sum !== want || e !== want) begin
                n_errors++;
                $display("FAIL directed_%0d: got vld=%b sum=%h expected 1 %h", t, out_valid, sum, want);
            end
            out_ready = 1'b1;
            step(1);
            out_ready = 1'b0;
            ov_allowed = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] e;
        for (int i = 0; i < 4; i++) pv[i] = 16'($urandom);
        feed(4, 16'($urandom), 1'b0, e);
        ov_allowed = 1'b1;
        step(2);
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== e) begin
                n_errors++;
                $display("FAIL hold_%0d: got vld=%b rdy=%b sum=%h expected 1 0 %h", c, out_valid, in_ready, sum, e);
            end
            step(1);
        end
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        ov_allowed = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_release: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] e;
        pv[0] = 16'h3123; pv[1] = 16'h2456;
        feed(2, 16'h1111, 1'b0, e);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0000) begin
            n_errors++;
            $display("FAIL midreset_state: got rdy=%b vld=%b sum=%h expected 1 0 0000", in_ready, out_valid, sum);
        end
        for (int i = 0; i < 4; i++) pv[i] = 16'h0800;
        feed(4, 16'h0000, 1'b1, e);
        ov_allowed = 1'b1;
        step(2);
        n_checks++;
        if (out_valid !== 1'b1 || sum !== 16'h2000) begin
            n_errors++;
            $display("FAIL midreset_sum: got vld=%b sum=%h expected 1 2000", out_valid, sum);
        end
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        ov_allowed = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] e;
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 1) == 1) pv[i] = 16'($urandom);
                else pv[i] = {1'($urandom), 3'b000, 12'($urandom)};
            end
            feed(4, 16'($urandom), 1'b1, e);
            ov_allowed = 1'b1;
            step(2);
            n_checks++;
            if (out_valid !== 1'b1 || sum !== e) begin
                n_errors++;
                $display("FAIL random_%0d: got vld=%b sum=%h expected 1 %h", t, out_valid, sum, e);
            end
            out_ready = 1'b1;
            step(1);
            out_ready = 1'b0;
            ov_allowed = 1'b0;
        end
    endtask

    task automatic test_full_scale();
        logic [15:0] p, b, want;
        for (int t = 0; t < 2; t++) begin
            p = (t == 0) ? 16'h7FFF : 16'hFFFF;
            b = (t == 0) ? 16'h7FFF : 16'h0000;
`ifdef AKUMULATOR_RELU_EN
            want = (t == 0) ? 16'h7FFF : 16'h0000;
`else
            want = (t == 0) ? 16'h7FFF : 16'hFFFF;
`endif
            for (int i = 0; i < 60; i++) begin
                in_valid60 = 1'b1;
                product60  = p;
                bias60     = (i == 0) ? b : 16'($urandom);
                step(1);
            end
            in_valid60 = 1'b0;
            step(2);
            n_checks++;
            if (out_valid60 !== 1'b1 || sum60 !== want) begin
                n_errors++;
                $display("FAIL full_scale_%0d: got vld=%b sum=%h expected 1 %h", t, out_valid60, sum60, want);
            end
            out_ready60 = 1'b1;
            step(1);
            out_ready60 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_full_scale();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/akumulator_neurona.md
AKUMULATOR_NEURONA -- requirements
Module: akumulator_neurona

Interface
REQ-001 SHALL have parameter N_INPUTS, default 60, number of products summed per neuron evaluation (range 2..255).
REQ-002 SHALL have parameter ACC_W, default 24, internal two's-complement accumulator width (range 17..32).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  product word valid.
REQ-006 SHALL have port in_ready  output  1  block accepts product this cycle.
REQ-007 SHALL have port product  input  16  multiplier output, sign-magnitude Q3.12 (bit 15 sign, bits 14:0 magnitude).
REQ-008 SHALL have port bias  input  16  neuron bias, sign-magnitude Q3.12.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port sum  output  16  neuron pre-activation result, sign-magnitude Q3.12.

Function
REQ-012 SHALL implement FSM states ACC, BIAS, SAT, OUT; reset state ACC.
REQ-013 In ACC, in_ready SHALL be 1; a product is accepted when in_valid && in_ready.
REQ-014 Each accepted product SHALL be converted to two's complement, sign-extended to ACC_W and added to the accumulator; the 8-bit count SHALL increment.
REQ-015 bias SHALL be captured on the cycle the first product (count 0) is accepted.
REQ-016 When the N_INPUTS-th product is accepted, the FSM SHALL go to BIAS and count SHALL return to 0.
REQ-017 BIAS SHALL add the captured bias (two's complement, sign-extended) to the accumulator in one cycle, then go to SAT.
REQ-018 SAT SHALL clamp the accumulator to [-32767, +32767], convert to sign-magnitude, register into sum, then go to OUT.
REQ-019 In OUT, out_valid SHALL be 1 and sum stable; on out_ready the FSM SHALL clear the accumulator and return to ACC.
REQ-020 in_ready SHALL be 0 in BIAS, SAT and OUT (back-pressure to the multiplier).
REQ-021 Latency: out_valid SHALL rise exactly 2 cycles after the cycle accepting the last product.
REQ-022 Negative zero (0x8000) on product or bias SHALL be treated as 0; sum SHALL never be 0x8000 (zero is 0x0000).
REQ-023 Accumulator SHALL not wrap for N_INPUTS x 0x7FFF plus bias at default ACC_W; saturation happens only in SAT.

Reset
REQ-024 On rst: state ACC, accumulator 0, count 0, captured bias 0, sum 0x0000, out_valid 0, in_ready 1 on the following cycle.
REQ-025 rst mid-accumulation or in OUT SHALL discard the partial/pending result with no out_valid pulse.

Configuration
REQ-026 Macro AKUMULATOR_RELU_EN: when defined, SAT SHALL output 0x0000 for any negative clamped result (ReLU fused); when undefined, negative results SHALL pass as sign-magnitude.

Structure
REQ-027 Package ann_pkg SHALL hold DATA_W=16, FRAC_W=12, SM_MAX=16'h7FFF and the FSM state enum.
REQ-028 Sign-magnitude/two's-complement conversion SHALL be sub-module sm_pretvorba, instanced for product and bias.

Verification (bench N_INPUTS=4 unless stated)
REQ-029 4 x 0x1000, bias 0x0000 -> sum 0x4000 (4.0), out_valid 2 cycles after 4th accept.
REQ-030 4 x 0x9000, bias 0x1000 -> sum 0xB000 (-3.0); with AKUMULATOR_RELU_EN -> 0x0000.
REQ-031 N_INPUTS=60, 60 x 0x7FFF, bias 0x7FFF -> sum 0x7FFF; 60 x 0xFFFF -> 0xFFFF.
REQ-032 out_ready held 0 for 5 cycles in OUT -> sum and out_valid stable, in_ready 0; accepted on 6th cycle, in_ready 1 next cycle.
REQ-033 rst after 2 products, then 4 x 0x0800, bias 0x0000 -> sum 0x2000, no earlier out_valid.
REQ-034 4 x 0x8000, bias 0x8000 -> sum 0x0000.
